bpsk_frame_receiver: RTL
========================

# bpsk_frame_receiver

Byte framer that sits directly downstream of the BPSK signal demodulator. It consumes the demodulator's per-symbol `guess` bit and its toggle-style `write` strobe. It hunts for a sync word, then extracts a length-prefixed payload with an XOR checksum. Payload bytes are emitted one at a time with a single-cycle valid pulse, and frame status is reported at the end of each frame.

## Interface
- `SYNC_WORD`, 8'hD5: sync pattern, MSB first.
- `MAX_LEN`, 64: largest accepted payload length, in bytes.
- `SYMBOL_TIMEOUT`, 4096: clocks allowed without a bit event before an in-frame abort; must be less than 2^16.

- `clock` input 1: sole clock. Every register updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `guess` input 1: demodulated bit, sampled only on a bit event.
- `write` input 1: demodulator strobe. Each toggle (either direction) marks one new `guess`.
- `data` output 8: payload byte, valid while `data_valid`=1.
- `data_valid` output 1: one-cycle pulse per payload byte.
- `frame_start` output 1: one-cycle pulse when the sync word matches.
- `frame_end` output 1: one-cycle pulse when the checksum byte has been received.
- `frame_ok` output 1: checksum result; meaningful only while `frame_end`=1, 0 otherwise.
- `len_err` output 1: one-cycle pulse when the length byte is rejected.
- `timeout` output 1: one-cycle pulse on an in-frame symbol timeout.
- `busy` output 1: 1 whenever the state is not HUNT.

## Operation
- **Bit event detection**
  - `write` is registered into `write_q`.
  - A `primed` flag is cleared by reset. The first clock after reset loads `write_q` and sets `primed`, and generates no event.
  - After that, `bit_evt = primed & (write ^ write_q)`.
- **HUNT**
  - On each `bit_evt`, an 8-bit sliding window shifts `guess` in at the LSB.
  - When the post-shift window equals `SYNC_WORD`, pulse `frame_start`, clear the bit counter and go to LEN.
- **Byte assembly (LEN, PAYLOAD, CHECK)**
  - Bits assemble MSB first.
  - A 3-bit counter wraps 7→0. A byte completes on the 8th `bit_evt`.
- **LEN**
  - Length byte L = 0 or L > `MAX_LEN`: pulse `len_err`, go to HUNT.
  - Otherwise: store L, set checksum = L, clear the byte counter, go to PAYLOAD.
- **PAYLOAD**
  - For each completed byte B: drive `data`=B, pulse `data_valid`, set checksum ^= B, increment the byte counter.
  - After byte L, go to CHECK.
- **CHECK**
  - On the completed byte C: pulse `frame_end`, drive `frame_ok` = (C == checksum) for that cycle, go to HUNT.
- **Sliding window clearing**
  - The window clears to 0 on every entry to HUNT, so a new sync needs 8 fresh bits.
  - Exception: if `SYNC_WORD` = 8'h00, the window never matches until 8 bits have been received since entering HUNT.
- **Timeout**
  - A 16-bit idle counter resets on every `bit_evt` and on entering HUNT.
  - It increments otherwise while not in HUNT.
  - On reaching `SYMBOL_TIMEOUT`: pulse `timeout`, go to HUNT. Partial payload bytes are discarded; no `frame_end`.
- **Simultaneous events**
  - If `bit_evt` coincides with the terminal count, `bit_evt` wins: the counter resets and the bit is processed.
- **`data` hold rule**
  - `data` holds its last value between pulses.
  - Status pulses (`len_err`, `frame_end`) never coincide with `data_valid`.

## Timing
- **Reset values:** all outputs 0, state HUNT, window 0, `write_q` 0, `primed` 0, every counter 0.
  - Reset asserted mid-frame aborts immediately; no pulses are emitted for the aborted frame.
- **Latency:**
  - Bit consumed at the rising edge ending the cycle in which `bit_evt`=1.
  - `data_valid`, `frame_start`, `frame_end`/`frame_ok`, `len_err` and `timeout` are registered outputs, high for exactly the one following cycle.
- **Toggle rate:** back-to-back toggles on consecutive clocks are legal; each is one bit, with no minimum spacing.
- **No back-pressure:** the downstream consumer must accept `data` in the `data_valid` cycle.
- **Timeout boundary:** the `timeout` pulse occurs in the cycle after the counter reaches `SYMBOL_TIMEOUT`, i.e. `SYMBOL_TIMEOUT`+1 clocks after the last `bit_evt`.

## Test plan
- **Nominal frame:** bits D5, 02, 12, 34, 24 with toggles every 4 clocks → `frame_start` once; `data_valid` with 0x12 then 0x34; `frame_end`=1 with `frame_ok`=1; `busy` falls after `frame_end`.
- **Bad checksum:** same frame with checksum 0x25 → both bytes emitted; `frame_end`=1, `frame_ok`=0.
- **Length errors:** sync followed by length 0x00 → `len_err` pulse, no `data_valid`. Repeat with 0x41 (`MAX_LEN`=64) → `len_err`.
- **Unaligned sync:** prefix bits 1,0,1,1 then D5, 01, AA, AB → `frame_start` exactly after the 12th bit; `data` 0xAA; `frame_ok`=1.
- **Timeout:** stop toggling after 4 payload bits with `SYMBOL_TIMEOUT`=16 → `timeout` pulse 17 clocks after the last toggle, no `frame_end`. A following complete frame is received correctly.
- **Reset handling:**
  - Hold `write`=1 through `reset_n` release → no bit is consumed.
  - Assert `reset_n`=0 mid-payload → all outputs 0 at once, state HUNT, next frame decoded normally.

Source files
------------

// File: rtl/bpsk_frame_receiver.sv
// bpsk_frame_receiver: hunts for a sync word in the demodulated bit stream, then frames a length-prefixed, XOR-checked payload
module bpsk_frame_receiver #(
    parameter logic [7:0] SYNC_WORD      = 8'hD5,
    parameter int         MAX_LEN        = 64,
    parameter int         SYMBOL_TIMEOUT = 4096
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       guess,
    input  logic       write,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_ok,
    output logic       len_err,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

    state_t      state_q, state_d;
    logic        write_q, primed_q;
    logic [6:0]  win_q, win_d;
    logic [3:0]  hcnt_q, hcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  nbytes_q, nbytes_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        frame_ok_q, frame_ok_d;
    logic        len_err_q, len_err_d;
    logic        timeout_q, timeout_d;

    logic        bit_evt;
    logic        in_hunt;
    logic        byte_done;
    logic        sync_hit;
    logic        len_bad;
    logic        last_payload;
    logic        tmo;
    logic        enter_hunt;
    logic [7:0]  win_next;
    logic [7:0]  byte_now;

    // The first clock after reset only captures the strobe level, so a held strobe is never a bit
    assign bit_evt      = primed_q & (write ^ write_q);
    assign in_hunt      = (state_q == HUNT);
    assign win_next     = {win_q, guess};
    assign byte_now     = {shift_q, guess};
    assign byte_done    = bit_evt & ~in_hunt & (bcnt_q == 3'd7);
    assign sync_hit     = in_hunt & bit_evt & (win_next == SYNC_WORD) &
                          ((SYNC_WORD != 8'h00) | (hcnt_q >= 4'd7));
    assign len_bad      = (byte_now == 8'd0) | (byte_now > 8'(MAX_LEN));
    assign last_payload = (nbytes_q == len_q - 8'd1);
    // A bit arriving on the terminal count takes priority over the abort
    assign tmo          = ~in_hunt & ~bit_evt & (idle_q == 16'(SYMBOL_TIMEOUT));
    assign enter_hunt   = ~in_hunt & (state_d == HUNT);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sync opens a frame, length/payload/checksum bytes advance it, timeout aborts it
    always_comb begin
        state_d = state_q;
        if (tmo) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT:    state_d = sync_hit ? LEN : HUNT;
                LEN:     state_d = byte_done ? (len_bad ? HUNT : PAYLOAD) : LEN;
                PAYLOAD: state_d = (byte_done && last_payload) ? CHECK : PAYLOAD;
                CHECK:   state_d = byte_done ? HUNT : CHECK;
                default: state_d = HUNT;
            endcase
        end
    end

    // Output pulses for the following cycle; data holds its last byte between pulses
    always_comb begin
        frame_start_d = sync_hit;
        len_err_d     = (state_q == LEN) & byte_done & len_bad;
        data_valid_d  = (state_q == PAYLOAD) & byte_done;
        data_d        = data_valid_d ? byte_now : data_q;
        frame_end_d   = (state_q == CHECK) & byte_done;
        frame_ok_d    = frame_end_d & (byte_now == csum_q);
        timeout_d     = tmo;
    end

    // Datapath next values: sync window, bit/byte assembly, checksum and idle counter
    always_comb begin
        win_d    = enter_hunt ? 7'd0 : (in_hunt && bit_evt) ? win_next[6:0] : win_q;
        hcnt_d   = enter_hunt ? 4'd0 :
                   (in_hunt && bit_evt && hcnt_q != 4'd8) ? hcnt_q + 4'd1 : hcnt_q;
        bcnt_d   = (sync_hit || enter_hunt) ? 3'd0 :
                   (!in_hunt && bit_evt) ? bcnt_q + 3'd1 : bcnt_q;
        shift_d  = (!in_hunt && bit_evt) ? byte_now[6:0] : shift_q;
        len_d    = (state_q == LEN && byte_done) ? byte_now : len_q;
        csum_d   = (state_q == LEN && byte_done) ? byte_now :
                   (state_q == PAYLOAD && byte_done) ? csum_q ^ byte_now : csum_q;
        nbytes_d = (state_q == LEN && byte_done) ? 8'd0 :
                   (state_q == PAYLOAD && byte_done) ? nbytes_q + 8'd1 : nbytes_q;
        idle_d   = (bit_evt || in_hunt || state_d == HUNT) ? 16'd0 : idle_q + 16'd1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q       <= 1'b0;
            primed_q      <= 1'b0;
            win_q         <= 7'd0;
            hcnt_q        <= 4'd0;
            bcnt_q        <= 3'd0;
            shift_q       <= 7'd0;
            len_q         <= 8'd0;
            nbytes_q      <= 8'd0;
            csum_q        <= 8'd0;
            idle_q        <= 16'd0;
            data_q        <= 8'd0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            write_q       <= write;
            primed_q      <= 1'b1;
            win_q         <= win_d;
            hcnt_q        <= hcnt_d;
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            len_q         <= len_d;
            nbytes_q      <= nbytes_d;
            csum_q        <= csum_d;
            idle_q        <= idle_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_ok_q    <= frame_ok_d;
            len_err_q     <= len_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_ok    = frame_ok_q;
    assign len_err     = len_err_q;
    assign timeout     = timeout_q;
    assign busy        = ~in_hunt;

endmodule
